mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter onto a single-outstanding memory port
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_valid,
   input  logic        flush,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic        m_ack,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 2);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t        state_q;
   logic          owner_data_q;
   logic          drop_q;
   logic [CW-1:0] starve_q;
   logic          m_req_q;
   logic          m_we_q;
   logic [31:0]   m_addr_q;
   logic [31:0]   m_wdata_q;
   logic [3:0]    m_be_q;

   logic i_elig;
   logic starve_hit;
   logic grant_i;
   logic grant_d;

   // A flush in the arbitration cycle means the fetch address is stale, so the fetch sits out.
   assign i_elig     = i_req & ~flush;
   assign starve_hit = (starve_q == LIMIT);
   assign grant_d    = d_req & ~(i_elig & starve_hit);
   assign grant_i    = i_elig & ~grant_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         owner_data_q <= 1'b0;
         drop_q       <= 1'b0;
         starve_q     <= '0;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_be_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_i || grant_d) begin
                  state_q      <= S_REQ;
                  m_req_q      <= 1'b1;
                  owner_data_q <= grant_d;
                  m_we_q       <= grant_d & d_we;
                  m_addr_q     <= grant_d ? d_addr : i_addr;
                  m_wdata_q    <= grant_d ? d_wdata : '0;
                  m_be_q       <= grant_d ? d_be : 4'hF;
               end
               if (grant_i || !i_elig)
                  starve_q <= '0;
               else if (grant_d && !starve_hit)
                  starve_q <= starve_q + CW'(1);
            end
            S_REQ: begin
               if (flush && !owner_data_q)
                  drop_q <= 1'b1;
               if (m_ack) begin
                  state_q <= S_WAIT;
                  m_req_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (flush && !owner_data_q)
                  drop_q <= 1'b1;
               if (m_rvalid) begin
                  state_q <= S_IDLE;
                  drop_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_be    = m_be_q;

   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   // A redirect arriving with the response still kills the stale fetch.
   assign i_valid = (state_q == S_WAIT) & m_rvalid & ~owner_data_q & ~drop_q & ~flush;
   assign d_valid = (state_q == S_WAIT) & m_rvalid & owner_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Bench plays the memory and both requesters; expectations come from a transaction-level model.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        flush = 1'b0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ack = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
      .flush(flush),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [31:0] mem_m [logic [31:0]];
   int ph = 0;
   int wcnt = 0;
   int cnt = 0;
   bit own_d = 0;
   bit dropped = 0;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = '0;
   logic [31:0] e_wdata = '0;
   logic [3:0]  e_be = '0;
   bit auto_req = 0;
   bit stray = 0;
   int ack_lat = 0;
   int rsp_lat = 0;
   bit got_i = 0;
   bit got_d = 0;
   int cyc_n = 0;
   int ivalid_cnt = 0;
   int reqcyc_cnt = 0;
   int ivalid_cyc = -1;
   int rsp_cyc = -1;
   int rise_cyc = -1;
   logic [31:0] rise_addr = '0;
   logic [31:0] last_idata = '0;
   logic last_iv = 1'b0;
   logic prev_mreq = 1'b0;
   logic [31:0] grant_log [$];

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] v;
      v = rd(a);
      for (int b = 0; b < 4; b++)
         if (be[b]) v[8*b +: 8] = d[8*b +: 8];
      mem_m[a] = v;
   endtask

   task automatic drive_auto();
      flush = 1'b0;
      if (got_i) begin
         got_i = 0;
         if ($urandom_range(0, 1) == 1) i_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         else i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
         i_req  = 1'b1;
         i_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      end
      if ($urandom_range(0, 6) == 0) begin
         flush = 1'b1;
         if (i_req) i_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      end
      if (got_d) begin
         got_d = 0;
         d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 1) == 0) begin
         d_req   = 1'b1;
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
         d_wdata = $urandom;
         d_be    = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
      end
   endtask

   // Arbitration rules of the spec, applied once per idle cycle.
   task automatic arbitrate();
      bit ie;
      bit gi;
      bit gd;
      ie = i_req && !flush;
      gd = d_req && !(ie && cnt == LIMIT);
      gi = ie && !gd;
      if (gd) begin
         own_d = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
      end else if (gi) begin
         own_d = 0; e_we = 1'b0; e_addr = i_addr; e_be = 4'hF;
      end
      if (gd || gi) begin
         ph   = 1;
         wcnt = stray ? $urandom_range(0, 2) : ack_lat;
      end
      if (gi || !ie) cnt = 0;
      else if (gd && cnt < LIMIT) cnt = cnt + 1;
   endtask

   task automatic cyc();
      logic exp_iv;
      logic exp_dv;
      logic [31:0] rsp;
      cyc_n++;
      if (auto_req) drive_auto();
      m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom; rsp = '0;
      if (ph == 1) begin
         if (wcnt == 0) m_ack = 1'b1; else wcnt--;
      end else if (ph == 2) begin
         if (wcnt == 0) begin
            m_rvalid = 1'b1;
            if (!(own_d && e_we)) begin rsp = rd(e_addr); m_rdata = rsp; end
         end else wcnt--;
      end
      if (stray) begin
         if (ph != 1 && $urandom_range(0, 3) == 0) m_ack = 1'b1;
         if (ph != 2 && $urandom_range(0, 3) == 0) m_rvalid = 1'b1;
      end
      @(negedge clk);
      exp_iv = (ph == 2) && m_rvalid && !own_d && !dropped && !flush;
      exp_dv = (ph == 2) && m_rvalid && own_d;
      chk1("m_req", m_req, ph == 1);
      if (ph == 1) begin
         reqcyc_cnt++;
         chk1("m_we", m_we, e_we);
         chk32("m_addr", m_addr, e_addr);
         chk32("m_be", 32'(m_be), 32'(e_be));
         if (own_d) chk32("m_wdata", m_wdata, e_wdata);
      end
      chk1("i_valid", i_valid, exp_iv);
      chk1("d_valid", d_valid, exp_dv);
      if (exp_iv) chk32("i_rdata", i_rdata, rsp);
      if (exp_dv && !e_we) chk32("d_rdata", d_rdata, rsp);
      if (m_req && !prev_mreq) begin
         rise_cyc = cyc_n; rise_addr = m_addr; grant_log.push_back(m_addr);
      end
      prev_mreq = m_req;
      last_iv = i_valid;
      if (i_valid) begin ivalid_cnt++; ivalid_cyc = cyc_n; last_idata = i_rdata; end
      if (exp_iv) got_i = 1;
      if (exp_dv) got_d = 1;
      if (ph != 0 && !own_d && flush) dropped = 1;
      if (ph == 1 && m_ack) begin
         ph = 2;
         wcnt = stray ? $urandom_range(0, 3) : rsp_lat;
      end else if (ph == 2 && m_rvalid) begin
         ph = 0; dropped = 0; rsp_cyc = cyc_n;
         if (own_d && e_we) wr(e_addr, e_wdata, e_be);
      end else if (ph == 0) begin
         arbitrate();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      i_req = 1'b0; d_req = 1'b0; flush = 1'b0;
      for (int k = 0; k < 50 && ph != 0; k++) cyc();
      chk1("drain_idle", ph == 0, 1'b1);
      cyc();
      got_i = 0; got_d = 0;
   endtask

   int t0;
   int n0;

   initial begin
      #2 rst = 1'b0;
      @(negedge clk);
      chk1("rst_m_req", m_req, 1'b0);
      chk1("rst_m_we", m_we, 1'b0);
      chk32("rst_m_addr", m_addr, 32'h0);
      chk32("rst_m_wdata", m_wdata, 32'h0);
      chk32("rst_m_be", 32'(m_be), 32'h0);
      chk1("rst_i_valid", i_valid, 1'b0);
      chk1("rst_d_valid", d_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc(); cyc();

      // single fetch: ack on first REQ cycle, response two cycles later
      mem_m[32'h100] = 32'h00500093;
      ack_lat = 0; rsp_lat = 1;
      i_req = 1'b1; i_addr = 32'h100;
      reqcyc_cnt = 0; t0 = cyc_n + 1; n0 = ivalid_cnt;
      for (int k = 0; k < 20 && !got_i; k++) cyc();
      i_req = 1'b0;
      chk1("fetch_done", got_i, 1'b1);
      got_i = 0;
      chk32("fetch_latency", 32'(ivalid_cyc - t0), 32'd3);
      chk32("fetch_req_cycles", 32'(reqcyc_cnt), 32'd1);
      chk32("fetch_pulses", 32'(ivalid_cnt - n0), 32'd1);
      chk32("fetch_data", last_idata, 32'h00500093);
      drain();

      // store held across a slow ack
      ack_lat = 2; rsp_lat = 1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      reqcyc_cnt = 0; n0 = ivalid_cnt;
      for (int k = 0; k < 20 && !got_d; k++) cyc();
      d_req = 1'b0;
      chk1("store_done", got_d, 1'b1);
      got_d = 0;
      chk32("store_req_cycles", 32'(reqcyc_cnt), 32'd3);
      chk32("store_no_ivalid", 32'(ivalid_cnt - n0), 32'd0);
      drain();

      // flush while the fetch is in WAIT, redirect to 0x200
      ack_lat = 0; rsp_lat = 2;
      i_req = 1'b1; i_addr = 32'h104; n0 = ivalid_cnt;
      cyc(); cyc();
      flush = 1'b1; i_addr = 32'h200;
      cyc();
      flush = 1'b0;
      for (int k = 0; k < 20 && rise_addr != 32'h200; k++) cyc();
      chk32("flush_wait_no_ivalid", 32'(ivalid_cnt - n0), 32'd0);
      chk32("refetch_addr", rise_addr, 32'h200);
      chk32("refetch_gap", 32'(rise_cyc - rsp_cyc), 32'd2);
      for (int k = 0; k < 20 && !got_i; k++) cyc();
      chk1("refetch_done", got_i, 1'b1);
      drain();

      // flush coincident with the response
      ack_lat = 0; rsp_lat = 1;
      i_req = 1'b1; i_addr = 32'h108;
      cyc(); cyc(); cyc();
      flush = 1'b1; i_addr = 32'h10C;
      cyc();
      flush = 1'b0;
      chk32("flush_rvalid_cycle", 32'(rsp_cyc), 32'(cyc_n));
      chk1("flush_rvalid_ivalid", last_iv, 1'b0);
      for (int k = 0; k < 20 && !got_i; k++) cyc();
      chk1("post_flush_fetch", got_i, 1'b1);
      drain();

      // contention: both ports held high
      ack_lat = 0; rsp_lat = 0;
      grant_log.delete();
      i_req = 1'b1; i_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2100; d_be = 4'hF; d_wdata = 32'h0;
      for (int k = 0; k < 200 && grant_log.size() < 10; k++) begin
         cyc();
         got_i = 0; got_d = 0;
      end
      chk32("contention_grants", 32'(grant_log.size()), 32'd10);
      for (int k = 0; k < 10 && k < grant_log.size(); k++)
         chk32($sformatf("contention_grant%0d", k), grant_log[k],
               (k % 5 == 4) ? 32'h300 : 32'h2100);
      drain();

      // randomized traffic with stray memory strobes
      auto_req = 1; stray = 1;
      for (int k = 0; k < 3000; k++) cyc();
      auto_req = 0; stray = 0;
      drain();

      // reset while in REQ
      ack_lat = 5;
      i_req = 1'b1; i_addr = 32'h400;
      cyc();
      chk1("pre_reset_m_req", m_req, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk1("reset_m_req", m_req, 1'b0);
      chk32("reset_m_addr", m_addr, 32'h0);
      chk32("reset_m_be", 32'(m_be), 32'h0);
      i_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      ph = 0; cnt = 0; dropped = 0; wcnt = 0; got_i = 0; prev_mreq = 1'b0;
      m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk1("late_rvalid_i_valid", i_valid, 1'b0);
      chk1("late_rvalid_d_valid", d_valid, 1'b0);
      chk1("late_rvalid_m_req", m_req, 1'b0);
      @(posedge clk); #1;
      m_rvalid = 1'b0;
      ack_lat = 0; rsp_lat = 0;
      i_req = 1'b1; i_addr = 32'h404;
      rise_addr = '0;
      cyc(); cyc();
      chk32("post_reset_grant", rise_addr, 32'h404);
      for (int k = 0; k < 20 && !got_i; k++) cyc();
      chk1("post_reset_fetch", got_i, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
